// File: rtl/norm_stream_ctrl.sv
// norm_stream_ctrl: frame sequencer and 3-stage normalisation pipeline for
// the AlexNet input stage. Each 8-bit sample becomes
// (x/255 - mean_c) * inv_std_c, emitted as a signed Q8.24 word.
//
// Optional build macro NORM_PLANAR_EN: the input is planar (the whole R plane,
// then G, then B) instead of interleaved RGB. When it is defined, FRAME_PIX
// must equal 3*PLANE_SIZE.
//
// Handshake: both stream interfaces use valid/ready. A transfer happens on a
// rising clk edge where valid && ready. A producer holding valid keeps its
// payload stable until the transfer. out_valid does not depend on out_ready.
// pix_ready is derived combinationally from state and out_ready only.
module norm_stream_ctrl #(
  parameter int FRAME_PIX  = 154587,
  parameter int CNT_W      = 18
`ifdef NORM_PLANAR_EN
  ,
  parameter int PLANE_SIZE = 51529
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_chan,
  output logic        out_last,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIX - 1);
`ifdef NORM_PLANAR_EN
  localparam logic [CNT_W-1:0] PLANE_LAST = CNT_W'(PLANE_SIZE - 1);
`endif

  // ImageNet defaults: mean as Q0.24, 1/std as Q4.12
  localparam logic [23:0] MEAN_R_RST = 24'd8136950;
  localparam logic [23:0] MEAN_G_RST = 24'd7650411;
  localparam logic [23:0] MEAN_B_RST = 24'd6811550;
  localparam logic [15:0] INV_R_RST  = 16'd17886;
  localparam logic [15:0] INV_G_RST  = 16'd18286;
  localparam logic [15:0] INV_B_RST  = 16'd18204;

  state_t state_q, state_d;
  logic done_q, done_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [1:0] ch_q, ch_d;
`ifdef NORM_PLANAR_EN
  logic [CNT_W-1:0] plane_cnt_q, plane_cnt_d;
`endif

  logic [23:0] mean_q [3];
  logic [23:0] mean_d [3];
  logic [15:0] inv_q [3];
  logic [15:0] inv_d [3];

  // Pipeline registers
  logic               s1_valid_q, s2_valid_q, s3_valid_q;
  logic [23:0]        s1_x_q;
  logic [1:0]         s1_ch_q, s2_ch_q, s3_ch_q;
  logic signed [24:0] s2_diff_q;
  logic [31:0]        s3_data_q;

  logic               en, in_acc, out_acc, start_acc;
  logic [23:0]        s1_x_d;
  logic [23:0]        mean_sel;
  logic [15:0]        inv_sel;
  logic signed [24:0] s2_diff_d;
  logic signed [41:0] prod;
  logic [31:0]        s3_data_d;

  // Handshake qualifiers and status outputs
  always_comb begin
    en        = !s3_valid_q || out_ready;
    pix_ready = (state_q == S_RUN) && en;
    in_acc    = pix_valid && pix_ready;
    out_acc   = s3_valid_q && out_ready;
    // a start coinciding with the done pulse is dropped
    start_acc = (state_q == S_IDLE) && start && !done_q;
    busy      = (state_q != S_IDLE);
    done      = done_q;
    out_valid = s3_valid_q;
    out_data  = s3_data_q;
    out_chan  = s3_ch_q;
    out_last  = s3_valid_q && (out_cnt_q == LAST_IDX);
    dbg_state = state_q;
  end

  // Frame FSM next-state and done pulse
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:  if (start_acc) state_d = S_RUN;
      S_RUN:   if (in_acc && (in_cnt_q == LAST_IDX)) state_d = S_DRAIN;
      S_DRAIN: begin
        if (out_acc && (out_cnt_q == LAST_IDX)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sample / output counters and the channel index
  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    ch_d      = ch_q;
`ifdef NORM_PLANAR_EN
    plane_cnt_d = plane_cnt_q;
`endif
    if (start_acc) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
      ch_d      = 2'd0;
`ifdef NORM_PLANAR_EN
      plane_cnt_d = '0;
`endif
    end else begin
      if (in_acc) begin
        in_cnt_d = in_cnt_q + CNT_W'(1);
`ifdef NORM_PLANAR_EN
        if (plane_cnt_q == PLANE_LAST) begin
          plane_cnt_d = '0;
          ch_d        = (ch_q == 2'd2) ? 2'd0 : ch_q + 2'd1;
        end else begin
          plane_cnt_d = plane_cnt_q + CNT_W'(1);
        end
`else
        ch_d = (ch_q == 2'd2) ? 2'd0 : ch_q + 2'd1;
`endif
      end
      if (out_acc) out_cnt_d = out_cnt_q + CNT_W'(1);
    end
  end

  // Constant registers: writable only while idle; addresses 6-7 do nothing
  always_comb begin
    mean_d = mean_q;
    inv_d  = inv_q;
    if (cfg_we && (state_q == S_IDLE)) begin
      case (cfg_addr)
        3'd0: mean_d[0] = cfg_wdata[23:0];
        3'd1: mean_d[1] = cfg_wdata[23:0];
        3'd2: mean_d[2] = cfg_wdata[23:0];
        3'd3: inv_d[0]  = cfg_wdata[15:0];
        3'd4: inv_d[1]  = cfg_wdata[15:0];
        3'd5: inv_d[2]  = cfg_wdata[15:0];
        default: ;
      endcase
    end
  end

  // Datapath arithmetic for the three stages
  always_comb begin
    // pix*65793 == pix replicated three times: Q0.24 of pix/255
    s1_x_d   = {pix_data, pix_data, pix_data};
    mean_sel = mean_q[0];
    inv_sel  = inv_q[0];
    case (s1_ch_q)
      2'd1:    mean_sel = mean_q[1];
      2'd2:    mean_sel = mean_q[2];
      default: mean_sel = mean_q[0];
    endcase
    case (s2_ch_q)
      2'd1:    inv_sel = inv_q[1];
      2'd2:    inv_sel = inv_q[2];
      default: inv_sel = inv_q[0];
    endcase
    s2_diff_d = $signed({1'b0, s1_x_q}) - $signed({1'b0, mean_sel});
    prod      = $signed(42'(s2_diff_q)) * $signed(42'({1'b0, inv_sel}));
    // Q1.24 * Q4.12 = Q.36; dropping 12 bits (floor) gives Q8.24
    s3_data_d = {{2{prod[41]}}, prod[41:12]};
  end

  // Control state, counters and constants
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      ch_q      <= 2'd0;
`ifdef NORM_PLANAR_EN
      plane_cnt_q <= '0;
`endif
      mean_q[0] <= MEAN_R_RST;
      mean_q[1] <= MEAN_G_RST;
      mean_q[2] <= MEAN_B_RST;
      inv_q[0]  <= INV_R_RST;
      inv_q[1]  <= INV_G_RST;
      inv_q[2]  <= INV_B_RST;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      ch_q      <= ch_d;
`ifdef NORM_PLANAR_EN
      plane_cnt_q <= plane_cnt_d;
`endif
      mean_q    <= mean_d;
      inv_q     <= inv_d;
    end
  end

  // Pipeline: every stage moves together on en, all hold when stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_ch_q    <= 2'd0;
      s2_diff_q  <= '0;
      s2_ch_q    <= 2'd0;
      s3_data_q  <= '0;
      s3_ch_q    <= 2'd0;
    end else if (en) begin
      s1_valid_q <= in_acc;
      s1_x_q     <= s1_x_d;
      s1_ch_q    <= ch_q;
      s2_valid_q <= s1_valid_q;
      s2_diff_q  <= s2_diff_d;
      s2_ch_q    <= s1_ch_q;
      s3_valid_q <= s2_valid_q;
      s3_data_q  <= s3_data_d;
      s3_ch_q    <= s2_ch_q;
    end
  end

endmodule

// File: tb/tb_norm_stream_ctrl.sv
// Directed bench for norm_stream_ctrl with a 6-sample frame.
module tb_norm_stream_ctrl;

  localparam int NPIX = 6;

  // Hand-computed Q8.24 results: floor(((p*65793) - mean) * inv / 4096)
  localparam logic [31:0] W255_R = 32'd37729438;
  localparam logic [31:0] W255_G = 32'd40745297;
  localparam logic [31:0] W255_B = 32'd44290763;
  localparam logic [31:0] W0_R   = -32'sd35531614;
  localparam logic [31:0] W0_G   = -32'sd34154155;
  localparam logic [31:0] W0_B   = -32'sd30272817;
  localparam logic [31:0] W128_R = 32'd1242561;
  localparam logic [31:0] W128_G = 32'd3442433;
  localparam logic [31:0] W128_B = 32'd7155176;
  localparam logic [31:0] W128_R_UNIT = 32'd8421504;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_chan;
  logic        out_last;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  norm_stream_ctrl #(.FRAME_PIX(NPIX), .CNT_W(18)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_last(out_last), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  // frame driver inputs
  logic [7:0]  frame_px [NPIX];
  logic [3:0]  rdy_pat;
  logic        busy_wr;
  // frame driver observations
  logic [31:0] obs_data [NPIX];
  logic [1:0]  obs_chan [NPIX];
  logic        obs_last [NPIX];
  int obs_n, first_acc, first_ov, last_out_cyc, done_cyc, hold_errs, extra_ready;

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Starts a frame, streams frame_px, applies rdy_pat to out_ready and records
  // accepted outputs. Returns in the cycle where done is seen (or on timeout).
  task automatic run_frame();
    int cyc;
    int n_in;
    logic stalled;
    logic [31:0] held_d;
    logic [1:0] held_c;
    logic held_l;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0; n_in = 0; obs_n = 0; first_acc = -1; first_ov = -1;
    last_out_cyc = -1; done_cyc = -1; hold_errs = 0; extra_ready = 0;
    stalled = 1'b0; held_d = '0; held_c = '0; held_l = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      obs_data[i] = 'x; obs_chan[i] = 'x; obs_last[i] = 1'bx;
    end
    while (cyc < 200) begin
      pix_valid = (n_in < NPIX);
      pix_data  = 8'd0;
      if (n_in < NPIX) pix_data = frame_px[n_in];
      out_ready = rdy_pat[cyc % 4];
      cfg_we    = busy_wr && (cyc == 1 || cyc == 2);
      cfg_addr  = (cyc == 1) ? 3'd0 : 3'd3;
      cfg_wdata = (cyc == 1) ? 32'd12345 : 32'd1;
      #1;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (n_in >= NPIX && pix_ready) extra_ready++;
      if (stalled && (!out_valid || out_data !== held_d || out_chan !== held_c
                      || out_last !== held_l)) hold_errs++;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (out_valid && out_ready) begin
        if (obs_n < NPIX) begin
          obs_data[obs_n] = out_data;
          obs_chan[obs_n] = out_chan;
          obs_last[obs_n] = out_last;
        end
        obs_n++;
        last_out_cyc = cyc;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        held_d = out_data; held_c = out_chan; held_l = out_last;
      end else begin
        stalled = 1'b0;
      end
      if (pix_valid && pix_ready) begin
        if (first_acc < 0) first_acc = cyc;
        n_in++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    pix_valid = 1'b0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL reset_pix_ready: got %b expected 0", pix_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    checks++; if (out_chan !== 2'd0) begin failures++; $display("FAIL reset_out_chan: got %0d expected 0", out_chan); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
  endtask

  task automatic test_default_consts();
    for (int i = 0; i < NPIX; i++) frame_px[i] = 8'd255;
    rdy_pat = 4'b1111;
    exp_q = {W255_R, W255_G, W255_B, W255_R, W255_G, W255_B};
    run_frame();
    checks++; if (obs_n != NPIX || done_cyc < 0) begin failures++; $display("FAIL defaults_count: got %0d words done_cyc %0d expected %0d words with done", obs_n, done_cyc, NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      exp_w = exp_q.pop_front();
      checks++; if (obs_data[i] !== exp_w) begin failures++; $display("FAIL defaults_word%0d: got %0d expected %0d", i, $signed(obs_data[i]), $signed(exp_w)); end
      checks++; if (obs_chan[i] !== 2'(i % 3)) begin failures++; $display("FAIL defaults_chan%0d: got %0d expected %0d", i, obs_chan[i], i % 3); end
    end
  endtask

  task automatic test_latency();
    for (int i = 0; i < NPIX; i++) frame_px[i] = 8'd0;
    rdy_pat = 4'b1111;
    exp_q = {W0_R, W0_G, W0_B, W0_R, W0_G, W0_B};
    run_frame();
    checks++; if (first_ov - first_acc != 3) begin failures++; $display("FAIL latency: got %0d cycles expected 3", first_ov - first_acc); end
    checks++; if (obs_n != NPIX || done_cyc < 0) begin failures++; $display("FAIL latency_count: got %0d words expected %0d", obs_n, NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      exp_w = exp_q.pop_front();
      checks++; if (obs_data[i] !== exp_w) begin failures++; $display("FAIL zero_word%0d: got %0d expected %0d", i, $signed(obs_data[i]), $signed(exp_w)); end
    end
    checks++; if (obs_chan[0] !== 2'd0) begin failures++; $display("FAIL zero_chan0: got %0d expected 0", obs_chan[0]); end
  endtask

  task automatic test_back_to_back();
    frame_px[0] = 8'd255; frame_px[1] = 8'd0; frame_px[2] = 8'd128;
    frame_px[3] = 8'd255; frame_px[4] = 8'd0; frame_px[5] = 8'd128;
    rdy_pat = 4'b1001;  // out_ready 1,0,0,1 repeating
    exp_q = {W255_R, W0_G, W128_B, W255_R, W0_G, W128_B};
    run_frame();
    checks++; if (obs_n != NPIX) begin failures++; $display("FAIL stall_count: got %0d words expected %0d", obs_n, NPIX); end
    checks++; if (hold_errs != 0) begin failures++; $display("FAIL stall_hold: got %0d changes while stalled expected 0", hold_errs); end
    for (int i = 0; i < NPIX; i++) begin
      exp_w = exp_q.pop_front();
      checks++; if (obs_data[i] !== exp_w) begin failures++; $display("FAIL stall_word%0d: got %0d expected %0d", i, $signed(obs_data[i]), $signed(exp_w)); end
      checks++; if (obs_chan[i] !== 2'(i % 3)) begin failures++; $display("FAIL stall_chan%0d: got %0d expected %0d", i, obs_chan[i], i % 3); end
    end
  endtask

  task automatic test_frame_end();
    for (int i = 0; i < NPIX; i++) frame_px[i] = 8'd128;
    rdy_pat = 4'b1111;
    exp_q = {W128_R, W128_G, W128_B, W128_R, W128_G, W128_B};
    run_frame();
    checks++; if (done_cyc != last_out_cyc + 1) begin failures++; $display("FAIL done_timing: got cycle %0d expected %0d", done_cyc, last_out_cyc + 1); end
    checks++; if (extra_ready != 0) begin failures++; $display("FAIL ready_after_last: got %0d cycles expected 0", extra_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_at_done: got %b expected 0", busy); end
    for (int i = 0; i < NPIX; i++) begin
      exp_w = exp_q.pop_front();
      checks++; if (obs_data[i] !== exp_w) begin failures++; $display("FAIL end_word%0d: got %0d expected %0d", i, $signed(obs_data[i]), $signed(exp_w)); end
      checks++; if (obs_last[i] !== (i == NPIX - 1)) begin failures++; $display("FAIL last_flag%0d: got %b expected %b", i, obs_last[i], i == NPIX - 1); end
    end
    // start raised in the done cycle must be dropped
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_with_done: got busy %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width: got %b expected 0", done); end
  endtask

  task automatic test_cfg();
    cfg_write(3'd0, 32'd0);
    cfg_write(3'd3, 32'd4096);
    cfg_write(3'd6, 32'hFFFF_FFFF);
    cfg_write(3'd7, 32'd0);
    for (int i = 0; i < NPIX; i++) frame_px[i] = 8'd128;
    rdy_pat = 4'b1111;
    exp_q = {W128_R_UNIT, W128_G, W128_B, W128_R_UNIT, W128_G, W128_B};
    run_frame();
    for (int i = 0; i < NPIX; i++) begin
      exp_w = exp_q.pop_front();
      checks++; if (obs_data[i] !== exp_w) begin failures++; $display("FAIL cfg_word%0d: got %0d expected %0d", i, $signed(obs_data[i]), $signed(exp_w)); end
    end
    // writes issued while busy must not land
    busy_wr = 1'b1;
    exp_q = {W128_R_UNIT, W128_G, W128_B, W128_R_UNIT, W128_G, W128_B};
    run_frame();
    busy_wr = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      exp_w = exp_q.pop_front();
      checks++; if (obs_data[i] !== exp_w) begin failures++; $display("FAIL cfg_busy_word%0d: got %0d expected %0d", i, $signed(obs_data[i]), $signed(exp_w)); end
    end
  endtask

  task automatic test_midframe_reset();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    pix_valid = 1'b1; pix_data = 8'd0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 pix_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (pix_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_pix_ready: got %b expected 0", pix_ready); end
    checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL mid_reset_out_data: got %0h expected 0", out_data); end
    checks++; if (out_chan !== 2'd0) begin failures++; $display("FAIL mid_reset_out_chan: got %0d expected 0", out_chan); end
    // defaults restored and a clean frame starts at channel 0
    for (int i = 0; i < NPIX; i++) frame_px[i] = 8'd255;
    rdy_pat = 4'b1111;
    exp_q = {W255_R, W255_G, W255_B, W255_R, W255_G, W255_B};
    run_frame();
    checks++; if (obs_n != NPIX || done_cyc < 0) begin failures++; $display("FAIL post_reset_count: got %0d words expected %0d", obs_n, NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      exp_w = exp_q.pop_front();
      checks++; if (obs_data[i] !== exp_w) begin failures++; $display("FAIL post_reset_word%0d: got %0d expected %0d", i, $signed(obs_data[i]), $signed(exp_w)); end
      checks++; if (obs_chan[i] !== 2'(i % 3)) begin failures++; $display("FAIL post_reset_chan%0d: got %0d expected %0d", i, obs_chan[i], i % 3); end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = 8'd0;
    out_ready = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 32'd0;
    busy_wr = 1'b0; rdy_pat = 4'b1111;
    test_reset();
    test_default_consts();
    test_latency();
    test_back_to_back();
    test_frame_end();
    test_cfg();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
